// File: rtl/sample_frame_packer.sv
// sample_frame_packer: decimates the ADC word stream, frames captures on SR_OUT rising edges
// and streams header/data words through a small FIFO. Optional macro: PACKER_TEST_PATTERN_EN.
`default_nettype none

module sample_frame_packer #(
  parameter int CLK_PER_SAMPLE = 50,
  parameter int SAMPLE_PHASE   = 25,
  parameter int FRAME_LEN      = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter int STUCK_LIMIT    = 200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [15:0] DATA_IN,
  input  logic        SR_OUT_IN,
  output logic [31:0] M_DATA,
  output logic        M_LAST,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] OVERFLOW_CNT,
  output logic        SROUT_STUCK
);

  localparam int PH_W = $clog2(CLK_PER_SAMPLE);
  localparam int ST_W = $clog2(STUCK_LIMIT + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_PER_SAMPLE - 1);
  localparam logic [PH_W-1:0] PH_STROBE = PH_W'(SAMPLE_PHASE);
  localparam logic [ST_W-1:0] ST_MAX    = ST_W'(STUCK_LIMIT);
  localparam logic [15:0]     IDX_LAST  = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_SR = 2'd1,
    S_HEADER  = 2'd2,
    S_COLLECT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              sr_prev_q;
  logic              cap_sr_q;
  logic [15:0]       cap_data_q;
  logic [ST_W-1:0]   stuck_cnt_q, stuck_cnt_d;
  logic              stuck_q, stuck_d;
  logic [15:0]       idx_q, idx_d;
  logic              first_q, first_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       ovf_q;
  logic [AW:0]       wr_q, rd_q;
  logic [32:0]       mem_q [FIFO_DEPTH];

  logic              strobe;
  logic              rise;
  logic              push;
  logic              data_push;
  logic [32:0]       push_word;
  logic              w_sr;
  logic [15:0]       w_sample;
  logic              w_last;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [32:0]       head;

  assign strobe  = (phase_q == PH_STROBE);
  assign phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
  assign rise    = strobe & SR_OUT_IN & ~sr_prev_q;

  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    if (strobe) begin
      if (!SR_OUT_IN) begin
        stuck_cnt_d = '0;
      end else if (stuck_cnt_q != ST_MAX) begin
        stuck_cnt_d = stuck_cnt_q + ST_W'(1);
      end
    end
    stuck_d = ENABLE & (stuck_q | (strobe & (stuck_cnt_d == ST_MAX)));
  end

  // Sample 0 comes from the capture registers; later words take the live strobe sample.
  assign w_sr   = first_q ? cap_sr_q : SR_OUT_IN;
  assign w_last = (idx_q == IDX_LAST);

`ifdef PACKER_TEST_PATTERN_EN
  logic [15:0] ramp_q, ramp_d;

  always_comb begin
    ramp_d = ramp_q;
    if (state_q == S_HEADER) begin
      ramp_d = '0;
    end else if (data_push) begin
      ramp_d = ramp_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  assign w_sample = ramp_q;
`else
  assign w_sample = first_q ? cap_data_q : DATA_IN;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    first_d     = first_q;
    frame_cnt_d = frame_cnt_q;
    push        = 1'b0;
    data_push   = 1'b0;
    push_word   = '0;
    case (state_q)
      S_IDLE: begin
        if (ENABLE) state_d = S_WAIT_SR;
      end
      S_WAIT_SR: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
        end else if (rise && !stuck_q) begin
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        push        = 1'b1;
        push_word   = {1'b0, 8'hAA, 8'h00, frame_cnt_q};
        frame_cnt_d = frame_cnt_q + 16'd1;
        idx_d       = '0;
        first_d     = 1'b1;
        state_d     = S_COLLECT;
      end
      S_COLLECT: begin
        if (first_q || strobe) begin
          push      = 1'b1;
          data_push = 1'b1;
          push_word = {w_last, 8'h5D, 7'b0, w_sr, w_sample};
          first_d   = 1'b0;
          idx_d     = idx_q + 16'd1;
          if (w_last) state_d = ENABLE ? S_WAIT_SR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Extra pointer bit distinguishes full from empty; a pop frees the slot for a same-cycle push.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = ~empty & M_READY;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_word;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      sr_prev_q   <= 1'b0;
      cap_sr_q    <= 1'b0;
      cap_data_q  <= '0;
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      stuck_cnt_q <= stuck_cnt_d;
      stuck_q     <= stuck_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      frame_cnt_q <= frame_cnt_d;
      if (strobe) begin
        cap_data_q <= DATA_IN;
        cap_sr_q   <= SR_OUT_IN;
        sr_prev_q  <= SR_OUT_IN;
      end
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop)     rd_q <= rd_q + (AW+1)'(1);
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  assign head         = mem_q[rd_q[AW-1:0]];
  assign M_VALID      = ~empty;
  assign M_LAST       = empty ? 1'b0 : head[32];
  assign M_DATA       = empty ? 32'h0 : head[31:0];
  assign FRAME_CNT    = frame_cnt_q;
  assign OVERFLOW_CNT = ovf_q;
  assign SROUT_STUCK  = stuck_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_frame_packer.sv
// tb_sample_frame_packer: directed scenarios plus randomized traffic, all stream words checked
// against a strobe-level reference model of the framing rules.
`default_nettype none

module tb_sample_frame_packer;

  localparam int CPS = 4;
  localparam int SP  = 1;
  localparam int FL  = 4;
  localparam int FD  = 8;
  localparam int SL  = 5;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ENABLE = 1'b0;
  logic [15:0] DATA_IN = 16'h0;
  logic        SR_OUT_IN = 1'b0;
  logic [31:0] M_DATA;
  logic        M_LAST;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic [15:0] FRAME_CNT;
  logic [15:0] OVERFLOW_CNT;
  logic        SROUT_STUCK;

  sample_frame_packer #(
    .CLK_PER_SAMPLE(CPS),
    .SAMPLE_PHASE  (SP),
    .FRAME_LEN     (FL),
    .FIFO_DEPTH    (FD),
    .STUCK_LIMIT   (SL)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .DATA_IN     (DATA_IN),
    .SR_OUT_IN   (SR_OUT_IN),
    .M_DATA      (M_DATA),
    .M_LAST      (M_LAST),
    .M_VALID     (M_VALID),
    .M_READY     (M_READY),
    .FRAME_CNT   (FRAME_CNT),
    .OVERFLOW_CNT(OVERFLOW_CNT),
    .SROUT_STUCK (SROUT_STUCK)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: evaluated once per conversion strobe from the framing rules.
  logic [32:0] exp_q[$];
  int          ecnt = 0;
  int          m_rem = 0;
  int          m_idx = 0;
  int          m_scnt = 0;
  int          m_frames = 0;
  bit          m_prev = 1'b0;
  bit          m_flag = 1'b0;
  bit          s_sr;
  logic [15:0] s_dat;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
      ecnt = 0; m_rem = 0; m_idx = 0; m_scnt = 0; m_frames = 0;
      m_prev = 1'b0; m_flag = 1'b0;
    end else begin
      if (ecnt % CPS == SP) begin
        s_sr  = SR_OUT_IN;
        s_dat = DATA_IN;
        if (m_rem == 0 && ENABLE && s_sr && !m_prev && !m_flag) begin
          exp_q.push_back({1'b0, 8'hAA, 8'h00, 16'(m_frames)});
          m_frames++;
          m_idx = 0;
          m_rem = FL;
        end
        if (m_rem > 0) begin
`ifdef PACKER_TEST_PATTERN_EN
          s_dat = 16'(m_idx);
`endif
          exp_q.push_back({(m_idx == FL - 1), 8'h5D, 7'h0, s_sr, s_dat});
          m_idx++;
          m_rem--;
        end
        if (s_sr) begin
          if (m_scnt < SL) m_scnt++;
        end else begin
          m_scnt = 0;
        end
        m_flag = ENABLE && (m_flag || m_scnt == SL);
        m_prev = s_sr;
      end
      ecnt++;
    end
  end

  logic [32:0] mon_exp;

  always @(negedge CLK) begin
    if (RST) begin
      if (M_VALID && M_READY) begin
        mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        check("stream_word", {M_LAST, M_DATA}, mon_exp);
      end
      if (ecnt % CPS == SP) begin
        check("stuck_flag", 33'(SROUT_STUCK), 33'(ENABLE & m_flag));
        check("frame_cnt", 33'(FRAME_CNT), 33'(16'(m_frames)));
      end
    end
  end

  task automatic sync_ph2();
    do begin
      @(posedge CLK); #1;
    end while (ecnt % CPS != 2);
  endtask

  // One conversion period starting just after a strobe edge; rdy: 0, 1 or 2 = random.
  task automatic period(input bit en, input bit sr, input logic [15:0] d, input int rdy,
                        input bit rdat);
    ENABLE    = en;
    SR_OUT_IN = sr;
    for (int i = 0; i < CPS; i++) begin
      DATA_IN = rdat ? 16'($urandom) : d;
      M_READY = (rdy == 2) ? (($urandom % 4) != 0) : (rdy != 0);
      @(posedge CLK); #1;
    end
  endtask

  task automatic drain(input bit en);
    for (int i = 0; i < 40; i++) begin
      if (i > FL && exp_q.size() == 0) break;
      period(en, 1'b0, 16'h0, 1, 1'b0);
    end
    check("drain_empty", 33'(exp_q.size()), 33'd0);
    check("drain_valid", 33'(M_VALID), 33'd0);
  endtask

  bit sr_r = 1'b0;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", 33'(M_VALID), 33'd0);
    check("rst_data", {M_LAST, M_DATA}, 33'd0);
    check("rst_frame_cnt", 33'(FRAME_CNT), 33'd0);
    check("rst_ovf_cnt", 33'(OVERFLOW_CNT), 33'd0);
    check("rst_stuck", 33'(SROUT_STUCK), 33'd0);
    RST = 1'b1;
    sync_ph2();

    // Basic frame with header/sample-0 latency.
    period(1'b1, 1'b0, 16'h1234, 1, 1'b0);
    period(1'b1, 1'b1, 16'h1234, 1, 1'b0);
    check("lat_t1_valid", 33'(M_VALID), 33'd0);
    @(posedge CLK); #1;
    check("lat_t2_valid", 33'(M_VALID), 33'd1);
    check("lat_t2_hdr", {M_LAST, M_DATA}, {1'b0, 32'hAA00_0000});
    SR_OUT_IN = 1'b0;
    @(posedge CLK); #1;
`ifdef PACKER_TEST_PATTERN_EN
    check("lat_t3_s0", {M_LAST, M_DATA}, {1'b0, 32'h5D01_0000});
`else
    check("lat_t3_s0", {M_LAST, M_DATA}, {1'b0, 32'h5D01_1234});
`endif
    sync_ph2();
    repeat (3) period(1'b1, 1'b0, 16'h1234, 1, 1'b0);
    drain(1'b1);
    check("basic_frame_cnt", 33'(FRAME_CNT), 33'd1);

    // ENABLE drops after the second data word; frame completes, next rise ignored.
    period(1'b1, 1'b1, 16'h0A0A, 1, 1'b0);
    period(1'b0, 1'b0, 16'h0B0B, 1, 1'b0);
    repeat (3) period(1'b0, 1'b0, 16'h0C0C, 1, 1'b0);
    period(1'b0, 1'b1, 16'h0D0D, 1, 1'b0);
    drain(1'b0);
    check("endrop_frame_cnt", 33'(FRAME_CNT), 33'd2);

    // SR_OUT stuck high.
    for (int i = 0; i < 6; i++) begin
      period(1'b1, 1'b1, 16'(16'h3000 + i), 1, 1'b0);
      if (i == 3) check("stuck_before", 33'(SROUT_STUCK), 33'd0);
      if (i == 4) check("stuck_at_limit", 33'(SROUT_STUCK), 33'd1);
    end
    period(1'b1, 1'b0, 16'h3100, 1, 1'b0);
    period(1'b1, 1'b1, 16'h3200, 1, 1'b0);
    period(1'b1, 1'b0, 16'h3300, 1, 1'b0);
    check("stuck_no_frame", 33'(FRAME_CNT), 33'd3);
    check("stuck_sticky", 33'(SROUT_STUCK), 33'd1);
    period(1'b0, 1'b0, 16'h3400, 1, 1'b0);
    check("stuck_cleared", 33'(SROUT_STUCK), 33'd0);
    drain(1'b0);

    // Backpressure: three frames into an 8-entry FIFO with no readout.
    period(1'b1, 1'b0, 16'h0, 0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      period(1'b1, 1'b1, 16'(16'hC000 + f * 16), 0, 1'b0);
      for (int k = 1; k < FL; k++) period(1'b1, 1'b0, 16'(16'hC000 + f * 16 + k), 0, 1'b0);
    end
    check("ovf_cnt", 33'(OVERFLOW_CNT), 33'd7);
    check("ovf_valid", 33'(M_VALID), 33'd1);
    check("ovf_frame_cnt", 33'(FRAME_CNT), 33'd6);
    while (exp_q.size() > FD) void'(exp_q.pop_back());
    drain(1'b1);

    // Asynchronous reset in the middle of a frame.
    period(1'b1, 1'b1, 16'h7777, 1, 1'b0);
    period(1'b1, 1'b0, 16'h7778, 1, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("arst_valid", 33'(M_VALID), 33'd0);
    check("arst_frame_cnt", 33'(FRAME_CNT), 33'd0);
    check("arst_ovf_cnt", 33'(OVERFLOW_CNT), 33'd0);
    check("arst_data", {M_LAST, M_DATA}, 33'd0);
    @(posedge CLK); @(posedge CLK); #4;
    RST = 1'b1;
    sync_ph2();
    period(1'b1, 1'b0, 16'h5555, 1, 1'b0);
    period(1'b1, 1'b1, 16'h5555, 1, 1'b0);
    repeat (3) period(1'b1, 1'b0, 16'h5555, 1, 1'b0);
    drain(1'b1);
    check("arst_new_frame", 33'(FRAME_CNT), 33'd1);

    // Randomized traffic.
    for (int p = 0; p < 300; p++) begin
      if (($urandom % 4) == 0) sr_r = ~sr_r;
      period(($urandom % 8) != 0, sr_r, 16'h0, 2, 1'b1);
    end
    drain(1'b0);
    check("rand_ovf_cnt", 33'(OVERFLOW_CNT), 33'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sample_frame_packer.md
Name: sample_frame_packer

Overview:
- Consumes the CLK-domain 16-bit ADC word and SR_OUT flag delivered by the sampling/clock-crossing stage.
- Decimates the oversampled stream to one capture per conversion period, using a fixed phase counter.
- Frames captures on SR_OUT rising edges (header word, then FRAME_LEN data words) and buffers them in a small FIFO.
- Drives a valid/ready stream to the readout path; also reports SR_OUT stuck-high and FIFO overflow.

Parameters:
CLK_PER_SAMPLE, 50, CLK cycles per conversion period (≥3)
SAMPLE_PHASE, 25, phase-counter value at which a capture strobe fires (< CLK_PER_SAMPLE)
FRAME_LEN, 64, data words per frame (≥1, ≤65535)
FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥4)
STUCK_LIMIT, 200, consecutive high captures that declare SR_OUT stuck

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-low reset
ENABLE  input  1  level; 1 = arm framing
DATA_IN  input  16  sampled ADC word, CLK domain
SR_OUT_IN  input  1  sampled SR_OUT, CLK domain
M_DATA  output  32  stream word
M_LAST  output  1  marks last data word of a frame
M_VALID  output  1  stream valid
M_READY  input  1  stream ready
FRAME_CNT  output  16  frames started since reset, wraps
OVERFLOW_CNT  output  16  words dropped on full FIFO, saturates at 16'hFFFF
SROUT_STUCK  output  1  sticky stuck-high flag

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs 0; FIFO emptied; phase counter 0; state IDLE; sr_prev 0; stuck counter 0.
- Phase counter:
  - Free-runs 0..CLK_PER_SAMPLE-1, then wraps to 0.
  - strobe=1 for the single cycle in which counter==SAMPLE_PHASE.
  - On strobe: capture DATA_IN and SR_OUT_IN; then sr_prev <= SR_OUT_IN.
  - rise = strobe & SR_OUT_IN & ~sr_prev.
- Stuck detector:
  - Counts consecutive strobes with SR_OUT_IN=1; a strobe with SR_OUT_IN=0 clears the count.
  - Count saturates at STUCK_LIMIT; SROUT_STUCK=1 when count reaches STUCK_LIMIT.
  - SROUT_STUCK is sticky; it clears only on reset or while ENABLE=0.
- FSM:
  - IDLE: if ENABLE → WAIT_SR.
  - WAIT_SR:
    - if ~ENABLE → IDLE.
    - if rise & ~SROUT_STUCK → HEADER, latch capture as sample 0.
  - HEADER: one cycle. Push {8'hAA, 8'h00, FRAME_CNT}; FRAME_CNT++; → COLLECT with idx=0.
  - COLLECT:
    - On entry, push sample 0 the cycle after HEADER.
    - Thereafter push one data word on each strobe.
    - Data word = {8'h5D, 7'b0, sr_bit, sample}. M_LAST=1 when idx==FRAME_LEN-1.
    - After the last push: ENABLE ? WAIT_SR : IDLE.
  - SR_OUT rises during HEADER/COLLECT are ignored; frame length is fixed.
  - ENABLE deassert mid-frame: the current frame completes, then → IDLE.
- FIFO (33 bits: last+data):
  - Push when full: word dropped, OVERFLOW_CNT++ (saturating), FSM continues.
  - Push and pop in the same cycle when full: pop completes, push accepted.
  - M_VALID = ~empty. A word transfers when M_VALID & M_READY.
  - M_DATA/M_LAST stay stable while M_VALID & ~M_READY.
- Latency:
  - rise strobe (cycle t) → header written t+1 → M_VALID at t+2 if FIFO was empty.
  - Sample 0 written t+2.
- Reset mid-frame: everything clears immediately; the partial frame is discarded.

Optional Feature:
- Macro PACKER_TEST_PATTERN_EN.
- Defined: the captured sample is replaced by an internal 16-bit ramp. The ramp resets to 0 at HEADER and increments after each data push, so data words carry 0,1,…,FRAME_LEN-1. DATA_IN is ignored; SR_OUT handling is unchanged.
- Undefined: DATA_IN is captured; no ramp logic is present.

Test Plan:
All scenarios use CLK_PER_SAMPLE=4, SAMPLE_PHASE=1, FRAME_LEN=4, FIFO_DEPTH=8, STUCK_LIMIT=5.
- Basic frame: ENABLE=1, M_READY=1, DATA_IN=16'h1234, SR_OUT rises once → words AA00_0000, 5D01_1234, 5D00_1234 ×3; M_LAST on 4th data word; FRAME_CNT=1.
- Backpressure/overflow: M_READY=0 for three consecutive frames → 8 words buffered, 7 dropped, OVERFLOW_CNT=7; release M_READY → 8 words drain in order.
- Stuck: SR_OUT held 1 for 6 strobes → SROUT_STUCK=1 after 5th strobe; a later rise starts no frame; ENABLE=0 clears flag.
- ENABLE drop mid-frame at idx=1 → full 5-word frame emitted, then IDLE; next SR_OUT rise ignored.
- Async reset asserted mid-COLLECT → M_VALID=0 and counters 0 in the same cycle; next rise after ENABLE yields header AA00_0000.
- PACKER_TEST_PATTERN_EN defined → data words 5D01_0000, 5D00_0001, 5D00_0002, 5D00_0003 regardless of DATA_IN.
